// File: rtl/demux18_pkg.sv
// Shared types and helpers for the 1x8 demux round-robin scheduler.
package demux18_pkg;

  localparam int NCH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    XFER
  } state_t;

  function automatic logic [NCH-1:0] onehot8(input logic [2:0] s);
    logic [NCH-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_next8.sv
// Combinational finder: first set bit of mask at/after start (incl=1) or strictly after start (incl=0), wrapping.
module rr_next8
  import demux18_pkg::*;
(
  input  logic [NCH-1:0] mask,
  input  logic [2:0]     start,
  input  logic           incl,
  output logic [2:0]     idx,
  output logic           found
);

  logic [2:0] off;
  logic [2:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    off   = '0;
    cand  = '0;
    // With incl=0 the offset runs 1..8, so offset 8 wraps back to start itself.
    for (int unsigned k = 0; k < NCH; k++) begin
      off  = incl ? 3'(k) : 3'(k + 1);
      cand = start + off;
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux18_rr_sched.sv
// Round-robin burst scheduler driving the select and per-channel valids of a 1x8 stream demux.
module demux18_rr_sched
  import demux18_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     en_mask,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_data,
  input  logic           in_last,
  output logic           in_ready,
  output logic [7:0]     out_valid,
  output logic [DW-1:0]  out_data,
  input  logic [7:0]     out_ready,
  output logic [2:0]     sel,
  output logic           busy,
  output logic           burst_done
);

  localparam int             CW       = $clog2(BURST) + 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(BURST - 1);

  state_t          state, state_nx;
  logic [2:0]      sel_nx, ptr, ptr_nx;
  logic [CW-1:0]   beat_cnt, beat_nx;
  logic [2:0]      f_start, f_idx;
  logic            f_incl, f_found;
  logic            xfer, last_beat;

  // One finder shared: IDLE searches from ptr inclusive, the last beat searches after sel.
  rr_next8 u_next (
    .mask  (en_mask),
    .start (f_start),
    .incl  (f_incl),
    .idx   (f_idx),
    .found (f_found)
  );

  always_comb begin
    f_start    = (state == XFER) ? sel : ptr;
    f_incl     = (state != XFER);
    in_ready   = (state == XFER) && out_ready[sel];
    xfer       = in_valid && in_ready;
    last_beat  = xfer && ((beat_cnt == LAST_CNT) || in_last);
    out_valid  = ((state == XFER) && in_valid) ? onehot8(sel) : '0;
    out_data   = in_data;
    busy       = (state != IDLE);
    burst_done = last_beat;
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    ptr_nx   = ptr;
    beat_nx  = beat_cnt;
    case (state)
      IDLE: begin
        if (f_found) begin
          sel_nx   = f_idx;
          state_nx = SEL;
        end
      end
      SEL: begin
        beat_nx  = '0;
        state_nx = XFER;
      end
      XFER: begin
        if (xfer) beat_nx = beat_cnt + 1'b1;
        if (last_beat) begin
          ptr_nx = sel + 3'd1;
          if (f_found) begin
            sel_nx   = f_idx;
            state_nx = SEL;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      sel      <= sel_nx;
      ptr      <= ptr_nx;
      beat_cnt <= beat_nx;
    end
  end

endmodule
